servo_sd_adc_front: RTL and testbench

//   Per-axis sigma-delta front end feeding the servo core's comparator input path.
//   An external RC integrator and comparator close the loop. This block does three things:
//     - synchronises the async comparator;
//     - drives the 1-bit feedback pin;
//     - counts feedback ones over a fixed window.

---
 rtl/servo_sd_adc_front.sv | 97 +++++++++
 tb/tb_servo_sd_adc_front.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/servo_sd_adc_front.sv
// Per-axis sigma-delta front end: comparator synchroniser, 1-bit feedback driver and
// windowed ones counter producing position samples on a valid/ready interface.
module servo_sd_adc_front #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIN_BITS    = 8,
  parameter int unsigned OUT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             comp_async_i,
  output logic             fb_o,
  output logic [OUT_W-1:0] sample_o,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic             overrun_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_fb;
  logic [WIN_BITS-1:0]    r_win_cnt;
  logic [WIN_BITS:0]      r_acc;
  logic [OUT_W-1:0]       r_sample;
  logic                   r_valid;
  logic                   r_overrun;

  logic                   w_comp_s;
  logic                   w_win_end;
  logic [WIN_BITS:0]      w_res;
  logic [WIN_BITS-1:0]    w_sat;
  logic [OUT_W-1:0]       w_new_sample;

  logic                   w_fb_d;
  logic [WIN_BITS-1:0]    w_win_cnt_d;
  logic [WIN_BITS:0]      w_acc_d;
  logic [OUT_W-1:0]       w_sample_d;
  logic                   w_valid_d;
  logic                   w_overrun_d;

  assign w_comp_s  = r_sync[SYNC_STAGES-1];
  assign w_win_end = ena & (&r_win_cnt);

  // The last cycle's feedback bit is still in r_fb, so fold it in at window end.
  assign w_res        = r_acc + {{WIN_BITS{1'b0}}, r_fb};
  assign w_sat        = w_res[WIN_BITS] ? {WIN_BITS{1'b1}} : w_res[WIN_BITS-1:0];
  assign w_new_sample = w_sat[WIN_BITS-1 -: OUT_W];

  always_comb begin
    w_fb_d      = ena & ~w_comp_s;
    w_win_cnt_d = '0;
    w_acc_d     = '0;
    w_sample_d  = r_sample;
    w_valid_d   = r_valid;
    w_overrun_d = r_overrun;

    if (ena) begin
      w_win_cnt_d = r_win_cnt + WIN_BITS'(1);
      w_acc_d     = w_win_end ? '0 : w_res;
    end

    if (w_win_end) begin
      w_sample_d = w_new_sample;
      w_valid_d  = 1'b1;
      if (r_valid && !sample_ready_i) begin
        w_overrun_d = 1'b1;
      end
    end else if (r_valid && sample_ready_i) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_fb      <= 1'b0;
      r_win_cnt <= '0;
      r_acc     <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], comp_async_i};
      r_fb      <= w_fb_d;
      r_win_cnt <= w_win_cnt_d;
      r_acc     <= w_acc_d;
      r_sample  <= w_sample_d;
      r_valid   <= w_valid_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign fb_o           = r_fb;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_servo_sd_adc_front.sv
// Bench for servo_sd_adc_front: directed comparator patterns with a scoreboard of
// expected samples consumed whenever the DUT completes a handshake.
module tb_servo_sd_adc_front;

  localparam int unsigned Win  = 256;
  localparam int          AllLo = 1 << 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       comp = 1'b0;
  logic       ready = 1'b0;
  logic       fb;
  logic [7:0] sample;
  logic       valid;
  logic       overrun;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  servo_sd_adc_front #(
    .SYNC_STAGES(2),
    .WIN_BITS   (8),
    .OUT_W      (8)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .comp_async_i  (comp),
    .fb_o          (fb),
    .sample_o      (sample),
    .sample_valid_o(valid),
    .sample_ready_i(ready),
    .overrun_o     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Comparator low (feedback high) for relative cycles [lo_a, lo_b), high otherwise.
  task automatic run_pat(input int n, input int lo_a, input int lo_b);
    for (int i = 0; i < n; i++) begin
      comp = (i >= lo_a && i < lo_b) ? 1'b0 : 1'b1;
      tick();
    end
  endtask

  task automatic do_reset(input logic comp_v, input string tag);
    rst_n = 1'b0;
    ena   = 1'b0;
    ready = 1'b0;
    comp  = comp_v;
    #1;
    check({tag, "_rst_fb"}, fb, 0);
    check({tag, "_rst_sample"}, sample, 0);
    check({tag, "_rst_valid"}, valid, 0);
    check({tag, "_rst_overrun"}, overrun, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  // Consumer side: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) check("unexpected_sample", 1, 0);
      else check("sample", sample, exp_q.pop_front());
    end
  end

  initial begin
    // 1: comparator low -> feedback always high, saturated samples
    tick();
    do_reset(1'b0, "t1");
    ready = 1'b1;
    ena   = 1'b1;
    repeat (3) exp_q.push_back(8'hFF);
    run_pat(Win - 1, 0, AllLo);
    check("t1_valid_early", valid, 0);
    check("t1_fb_high", fb, 1);
    run_pat(1, 0, AllLo);
    check("t1_valid_first", valid, 1);
    tick();
    check("t1_valid_one_cycle", valid, 0);
    run_pat(2 * Win, 0, AllLo);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: comparator high -> feedback low, zero samples
    do_reset(1'b1, "t2");
    ready = 1'b1;
    ena   = 1'b1;
    repeat (2) exp_q.push_back(8'h00);
    run_pat(2 * Win + 1, 0, 0);
    check("t2_fb_low", fb, 0);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: toggling comparator -> half-scale, and 3-edge feedback latency
    do_reset(1'b0, "t3");
    ready = 1'b1;
    ena   = 1'b1;
    repeat (2) exp_q.push_back(8'h80);
    for (int i = 0; i < 2 * Win + 1; i++) begin
      comp = (i % 2 == 0);
      tick();
      if (i == 1) check("t3_fb_before_edge", fb, 1);
      if (i == 2) check("t3_fb_after_3_edges", fb, 0);
      if (i == 3) check("t3_fb_alternates", fb, 1);
    end
    check("t3_q_empty", exp_q.size(), 0);

    // 4: overrun when two windows end without acceptance
    do_reset(1'b1, "t4");
    ready = 1'b0;
    ena   = 1'b1;
    exp_q.push_back(8'hC0);
    run_pat(Win, 50, 114);
    check("t4_valid_w1", valid, 1);
    check("t4_sample_w1", sample, 8'h40);
    check("t4_overrun_w1", overrun, 0);
    run_pat(100, 44, 236);
    check("t4_sample_stable", sample, 8'h40);
    run_pat(Win - 100, 0, 136);
    check("t4_valid_w2", valid, 1);
    check("t4_sample_w2", sample, 8'hC0);
    check("t4_overrun_w2", overrun, 1);
    ready = 1'b1;
    tick();
    check("t4_valid_drop", valid, 0);
    check("t4_overrun_sticky", overrun, 1);
    check("t4_q_empty", exp_q.size(), 0);

    // 5: enable dropped mid-window discards the partial window
    do_reset(1'b0, "t5");
    ready = 1'b1;
    ena   = 1'b1;
    exp_q.push_back(8'hFF);
    run_pat(100, 0, AllLo);
    ena = 1'b0;
    run_pat(5, 0, AllLo);
    check("t5_fb_off", fb, 0);
    run_pat(5, 0, AllLo);
    ena = 1'b1;
    run_pat(Win - 1, 0, AllLo);
    check("t5_valid_early", valid, 0);
    run_pat(1, 0, AllLo);
    check("t5_valid_full_window", valid, 1);
    tick();
    check("t5_q_empty", exp_q.size(), 0);

    // 6: reset mid-window clears valid/overrun immediately
    do_reset(1'b0, "t6");
    ready = 1'b0;
    ena   = 1'b1;
    run_pat(2 * Win, 0, AllLo);
    check("t6_pre_overrun", overrun, 1);
    run_pat(50, 0, AllLo);
    rst_n = 1'b0;
    #1;
    check("t6_async_fb", fb, 0);
    check("t6_async_sample", sample, 0);
    check("t6_async_valid", valid, 0);
    check("t6_async_overrun", overrun, 0);
    tick();
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    exp_q.push_back(8'hFF);
    run_pat(Win - 1, 0, AllLo);
    check("t6_valid_early", valid, 0);
    run_pat(1, 0, AllLo);
    check("t6_valid_full_window", valid, 1);
    tick();
    check("t6_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
